// File: rtl/uart_console_master.sv
// uart_console_master: TileLink initiator feeding a memory-mapped UART from a
// local byte producer. Clears both UART FIFOs once after reset (CONTROL), then
// for each queued byte polls STATUS and writes the byte to TX_FIFO.
// Optional build macro UART_CONS_RX_EN adds receive polling and the
// rx_valid/rx_data outputs.
module uart_console_master #(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          POLL_GAP   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        busy,
`ifdef UART_CONS_RX_EN
  output logic        rx_valid,
  output logic [7:0]  rx_data,
`endif
  output logic        a_valid,
  input  logic        a_ready,
  output logic [2:0]  a_opcode,
  output logic [63:0] a_address,
  output logic [31:0] a_data,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  localparam logic [2:0]  OP_PUT   = 3'd0;
  localparam logic [2:0]  OP_GET   = 3'd4;
  localparam logic [63:0] OFF_RX   = 64'h0;
  localparam logic [63:0] OFF_TX   = 64'h4;
  localparam logic [63:0] OFF_STAT = 64'h8;
  localparam logic [63:0] OFF_CTRL = 64'hc;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [31:0] data;
  } a_req_t;

  typedef enum logic [3:0] {
    S_INIT, S_INIT_HOLD, S_IDLE, S_STAT_REQ, S_STAT_RSP,
    S_BACKOFF, S_TX_REQ, S_TX_HOLD
`ifdef UART_CONS_RX_EN
    , S_RX_REQ, S_RX_RSP
`endif
  } state_t;

  state_t                       state;
  a_req_t                       req;
  logic [GW-1:0]                gap;
  logic [FIFO_DEPTH-1:0][7:0]   mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         push, pop, init_st;

  function automatic a_req_t mk(input logic [2:0] op, input logic [63:0] off,
                                input logic [31:0] data);
    return '{op: op, addr: BASE_ADDR + off, data: data};
  endfunction

  assign a_opcode  = req.op;
  assign a_address = req.addr;
  assign a_data    = req.data;

  assign init_st  = (state == S_INIT) || (state == S_INIT_HOLD);
  assign tx_ready = (count != DEPTH_C) && !init_st;
  assign busy     = (count != '0) || (state != S_IDLE);
  assign push     = tx_valid & tx_ready;
  assign pop      = (state == S_TX_REQ) & a_valid & a_ready;

  // Only Tx-Full (and Rx-Valid/data byte when receive is built in) are decoded.
`ifdef UART_CONS_RX_EN
  logic unused_d;
  assign unused_d = ^d_data[31:8];
`else
  logic unused_d;
  assign unused_d = ^{d_data[31:4], d_data[2:0]};
`endif

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_data;

  // FIFO pointers and occupancy; wrap is free because depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus sequencer; request fields are registered on entry to each request
  // state and left untouched afterwards so they are held past acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      a_valid  <= 1'b0;
      d_ready  <= 1'b0;
      req      <= '0;
      gap      <= '0;
`ifdef UART_CONS_RX_EN
      rx_valid <= 1'b0;
      rx_data  <= '0;
`endif
    end else begin
`ifdef UART_CONS_RX_EN
      rx_valid <= 1'b0;
`endif
      case (state)
        // First cycle out of reset raises the request; then wait for accept.
        S_INIT: begin
          if (!a_valid) begin
            a_valid <= 1'b1;
            req     <= mk(OP_PUT, OFF_CTRL, 32'h3);
          end else if (a_ready) begin
            a_valid <= 1'b0;
            state   <= S_INIT_HOLD;
          end
        end
        S_INIT_HOLD: begin
          state <= S_IDLE;
          gap   <= '0;
        end
        S_IDLE: begin
          if (count != '0) begin
            state   <= S_STAT_REQ;
            a_valid <= 1'b1;
            req     <= mk(OP_GET, OFF_STAT, 32'h0);
          end
`ifdef UART_CONS_RX_EN
          else if (gap == GAP_LAST) begin
            state   <= S_STAT_REQ;
            a_valid <= 1'b1;
            req     <= mk(OP_GET, OFF_STAT, 32'h0);
            gap     <= '0;
          end else begin
            gap <= gap + GW'(1);
          end
`endif
        end
        S_STAT_REQ: begin
          if (a_ready) begin
            a_valid <= 1'b0;
            d_ready <= 1'b1;
            state   <= S_STAT_RSP;
          end
        end
        S_STAT_RSP: begin
          if (d_valid) begin
            d_ready <= 1'b0;
`ifdef UART_CONS_RX_EN
            if (d_data[0]) begin
              state   <= S_RX_REQ;
              a_valid <= 1'b1;
              req     <= mk(OP_GET, OFF_RX, 32'h0);
            end else
`endif
            if (d_data[3]) begin
              state <= S_BACKOFF;
              gap   <= '0;
            end else if (count == '0) begin
              // Only reachable from an idle receive poll.
              state <= S_IDLE;
              gap   <= '0;
            end else begin
              state   <= S_TX_REQ;
              a_valid <= 1'b1;
              req     <= mk(OP_PUT, OFF_TX, {24'b0, mem[rd_ptr]});
            end
          end
        end
        S_BACKOFF: begin
          if (gap == GAP_LAST) begin
            state   <= S_STAT_REQ;
            a_valid <= 1'b1;
            req     <= mk(OP_GET, OFF_STAT, 32'h0);
            gap     <= '0;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        S_TX_REQ: begin
          if (a_ready) begin
            a_valid <= 1'b0;
            state   <= S_TX_HOLD;
          end
        end
        S_TX_HOLD: begin
          state <= S_IDLE;
          gap   <= '0;
        end
`ifdef UART_CONS_RX_EN
        S_RX_REQ: begin
          if (a_ready) begin
            a_valid <= 1'b0;
            d_ready <= 1'b1;
            state   <= S_RX_RSP;
          end
        end
        S_RX_RSP: begin
          if (d_valid) begin
            d_ready  <= 1'b0;
            rx_data  <= d_data[7:0];
            rx_valid <= 1'b1;
            state    <= S_STAT_REQ;
            a_valid  <= 1'b1;
            req      <= mk(OP_GET, OFF_STAT, 32'h0);
          end
        end
`endif
        default: begin
          state   <= S_INIT;
          a_valid <= 1'b0;
          d_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_console_master.sv
// Directed bench for uart_console_master with a small zero-wait TileLink
// responder: a_ready=1 unless a stall is requested, d_valid two negedges
// after a Get is accepted, STATUS values taken from a queue (0 when empty).
module tb_uart_console_master;

  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_ready, busy;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic [2:0]  a_opcode;
  logic [63:0] a_address;
  logic [31:0] a_data;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [31:0] d_data = 32'h0;
`ifdef UART_CONS_RX_EN
  logic        rx_valid;
  logic [7:0]  rx_data;
`endif

  uart_console_master #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .POLL_GAP(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .busy(busy),
`ifdef UART_CONS_RX_EN
    .rx_valid(rx_valid), .rx_data(rx_data),
`endif
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_address(a_address), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic d_acc = 1'b0;
  always @(posedge clk) d_acc <= d_valid & d_ready;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] stat_q[$];
  int          stall = 0;
  int          d_pend = 0;
  logic        hold_pend = 1'b0;
  logic [63:0] hold_addr;
  logic [31:0] hold_data;
  logic        sref_vld = 1'b0;
  logic [63:0] sref_addr;
  logic [31:0] sref_data;
  logic [2:0]  sref_op;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t ent(input int i);
    txn_t t;
    t.addr = '1; t.data = '1; t.op = '1; t.cyc = -1;
    if (i < log_q.size()) t = log_q[i];
    return t;
  endfunction

  // Responder and bus monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_ready   = 1'b1;
      d_valid   = 1'b0;
      d_pend    = 0;
      hold_pend = 1'b0;
      sref_vld  = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_a_valid", {63'b0, a_valid}, 64'd0);
        chk("hold_a_address", a_address, hold_addr);
        chk("hold_a_data", {32'b0, a_data}, {32'b0, hold_data});
        hold_pend = 1'b0;
      end
      if (d_acc) d_valid = 1'b0;
      if (d_pend > 0) begin
        d_pend--;
        if (d_pend == 0) begin
          d_valid = 1'b1;
          d_data  = (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0;
        end
      end
      if (a_valid && stall > 0) begin
        a_ready = 1'b0;
        stall--;
        if (sref_vld) begin
          chk("stall_addr", a_address, sref_addr);
          chk("stall_op", {61'b0, a_opcode}, {61'b0, sref_op});
          chk("stall_data", {32'b0, a_data}, {32'b0, sref_data});
        end else begin
          sref_vld = 1'b1; sref_addr = a_address; sref_op = a_opcode; sref_data = a_data;
        end
      end else begin
        a_ready = 1'b1;
        if (a_valid) begin
          txn_t t;
          if (sref_vld) begin
            chk("stall_acc_addr", a_address, sref_addr);
            chk("stall_acc_op", {61'b0, a_opcode}, {61'b0, sref_op});
            sref_vld = 1'b0;
          end
          t.addr = a_address; t.data = a_data; t.op = a_opcode; t.cyc = cyc;
          log_q.push_back(t);
          hold_pend = 1'b1; hold_addr = a_address; hold_data = a_data;
          if (a_opcode == 3'd4) d_pend = 2;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic exp_rdy, output int n);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    n = cyc;
    chk("tx_ready_at_push", {63'b0, tx_ready}, {63'b0, exp_rdy});
  endtask

  task automatic drop();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_log(input int n, input string tag);
    int t = 0;
    while (log_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(log_q.size() >= n), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, n0, nx, base;
    txn_t e;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_a_valid", {63'b0, a_valid}, 64'd0);
    chk("rst_d_ready", {63'b0, d_ready}, 64'd0);
    chk("rst_a_address", a_address, 64'd0);
    chk("rst_a_data", {32'b0, a_data}, 64'd0);
    chk("rst_a_opcode", {61'b0, a_opcode}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd1);
    chk("rst_tx_ready", {63'b0, tx_ready}, 64'd0);

    // Single CONTROL write after release, then quiet
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("init_count", 64'(log_q.size()), 64'd1);
    e = ent(0);
    chk("init_addr", e.addr, BASE + 64'hc);
    chk("init_data", {32'b0, e.data}, 64'h3);
    chk("init_op", {61'b0, e.op}, 64'd0);
    chk("init_busy", {63'b0, busy}, 64'd0);
    chk("init_tx_ready", {63'b0, tx_ready}, 64'd1);

    // One byte, STATUS=0, latency from push
    base = log_q.size();
    push(8'h41, 1'b1, n);
    drop();
    wait_cyc(n + 6);
    chk("t2_busy_hold", {63'b0, busy}, 64'd1);
    wait_cyc(n + 7);
    chk("t2_busy_done", {63'b0, busy}, 64'd0);
    chk("t2_count", 64'(log_q.size()), 64'(base + 2));
    e = ent(base);
    chk("t2_get_addr", e.addr, BASE + 64'h8);
    chk("t2_get_op", {61'b0, e.op}, 64'd4);
    chk("t2_get_cyc", 64'(e.cyc), 64'(n + 2));
    e = ent(base + 1);
    chk("t2_put_addr", e.addr, BASE + 64'h4);
    chk("t2_put_op", {61'b0, e.op}, 64'd0);
    chk("t2_put_data", {32'b0, e.data}, 64'h41);
    chk("t2_put_cyc", 64'(e.cyc), 64'(n + 5));

    // Fill the FIFO, fifth byte refused, ordering and 6-cycle cadence
    base = log_q.size();
    push(8'h48, 1'b1, n0);
    push(8'h69, 1'b1, n);
    push(8'h0a, 1'b1, n);
    push(8'h21, 1'b1, n);
    push(8'h99, 1'b0, nx);
    chk("t3_full_cyc", 64'(nx), 64'(n0 + 4));
    drop();
    wait_log(base + 8, "t3_wait");
    e = ent(base + 1); chk("t3_b0", {32'b0, e.data}, 64'h48); chk("t3_c0", 64'(e.cyc), 64'(n0 + 5));
    e = ent(base + 3); chk("t3_b1", {32'b0, e.data}, 64'h69); chk("t3_c1", 64'(e.cyc), 64'(n0 + 11));
    e = ent(base + 5); chk("t3_b2", {32'b0, e.data}, 64'h0a); chk("t3_c2", 64'(e.cyc), 64'(n0 + 17));
    e = ent(base + 7); chk("t3_b3", {32'b0, e.data}, 64'h21); chk("t3_c3", 64'(e.cyc), 64'(n0 + 23));
    repeat (12) @(negedge clk);
    chk("t3_no_extra", 64'(log_q.size()), 64'(base + 8));
    chk("t3_busy", {63'b0, busy}, 64'd0);

    // Tx-Full twice -> two 16-cycle backoffs, then one write
    base = log_q.size();
    stat_q.push_back(32'h8);
    stat_q.push_back(32'h8);
    stat_q.push_back(32'h0);
    push(8'h5a, 1'b1, n);
    drop();
    wait_log(base + 4, "t4_wait");
    e = ent(base);     chk("t4_get0", 64'(e.cyc), 64'(n + 2));
    e = ent(base + 1); chk("t4_get1", 64'(e.cyc), 64'(n + 21));
    chk("t4_get1_addr", e.addr, BASE + 64'h8);
    e = ent(base + 2); chk("t4_get2", 64'(e.cyc), 64'(n + 40));
    e = ent(base + 3);
    chk("t4_put_cyc", 64'(e.cyc), 64'(n + 43));
    chk("t4_put_addr", e.addr, BASE + 64'h4);
    chk("t4_put_data", {32'b0, e.data}, 64'h5a);
    repeat (12) @(negedge clk);
    chk("t4_no_dup", 64'(log_q.size()), 64'(base + 4));

    // Responder stalls the STATUS Get for 7 cycles
    base = log_q.size();
    stall = 7;
    push(8'h33, 1'b1, n);
    drop();
    wait_log(base + 2, "t5_wait");
    e = ent(base);
    chk("t5_get_cyc", 64'(e.cyc), 64'(n + 9));
    chk("t5_get_op", {61'b0, e.op}, 64'd4);
    e = ent(base + 1);
    chk("t5_put_data", {32'b0, e.data}, 64'h33);
    chk("t5_put_cyc", 64'(e.cyc), 64'(n + 12));

    // Reset while waiting for STATUS with two bytes queued
    repeat (4) @(negedge clk);
    push(8'ha1, 1'b1, n);
    push(8'hb2, 1'b1, nx);
    drop();
    wait_cyc(n + 3);
    chk("t6_in_rsp", {63'b0, d_ready}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_a_valid", {63'b0, a_valid}, 64'd0);
    chk("t6_rst_d_ready", {63'b0, d_ready}, 64'd0);
    chk("t6_rst_busy", {63'b0, busy}, 64'd1);
    chk("t6_rst_tx_ready", {63'b0, tx_ready}, 64'd0);
    base = log_q.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("t6_count", 64'(log_q.size()), 64'(base + 1));
    e = ent(base);
    chk("t6_ctrl_addr", e.addr, BASE + 64'hc);
    chk("t6_ctrl_data", {32'b0, e.data}, 64'h3);
    chk("t6_busy", {63'b0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
